// File: rtl/fetch_unit.sv
// Instruction-fetch / memory-read stage: holds PC, MAR, IR and MDR and runs the
// single-outstanding memory read handshake on behalf of the multicycle control unit.
module fetch_unit #(
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned OPC_W    = 4,
  parameter int unsigned RESET_PC = 0,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              iord,
  input  logic              pc_write,
  input  logic              pc_src,
  input  logic              mem_read,
  input  logic              ir_write,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_req,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] ir,
  output logic [OPC_W-1:0]  opcode,
  output logic [DATA_W-1:0] mdr,
  output logic              busy,
  output logic              bus_err
);

  localparam int unsigned CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] ir_q;
  logic [DATA_W-1:0] mdr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              ir_load_q;
  logic              bus_err_q;

  // PC updates are independent of the read FSM; the MAR is already latched.
  always_comb begin
    pc_d = pc_q;
    if (pc_write) begin
      pc_d = pc_src ? jump_target : pc_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      pc_q       <= ADDR_W'(RESET_PC);
      mem_addr_q <= '0;
      ir_q       <= '0;
      mdr_q      <= '0;
      cnt_q      <= '0;
      ir_load_q  <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      pc_q <= pc_d;
      case (state_q)
        IDLE: begin
          if (mem_read) begin
            mem_addr_q <= iord ? data_addr : pc_q;
            ir_load_q  <= ir_write;
            cnt_q      <= '0;
            state_q    <= REQ;
          end
        end
        REQ: begin
          // An ack arriving on the timeout edge still completes normally.
          if (mem_ack) begin
            mdr_q <= mem_rdata;
            if (ir_load_q) begin
              ir_q <= mem_rdata;
            end
            state_q <= IDLE;
          end else if (cnt_q == CNT_LAST) begin
            bus_err_q <= 1'b1;
            state_q   <= IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_addr = mem_addr_q;
  assign mem_req  = (state_q == REQ);
  assign busy     = (state_q == REQ);
  assign pc       = pc_q;
  assign ir       = ir_q;
  assign opcode   = ir_q[DATA_W-1 -: OPC_W];
  assign mdr      = mdr_q;
  assign bus_err  = bus_err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: each issued read pushes its expected address
// and data; completions pop and compare MDR/IR/opcode against the bench's own model.
module tb_fetch_unit;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned OPC_W  = 4;

  logic              clk;
  logic              reset;
  logic              iord, pc_write, pc_src, mem_read, ir_write, mem_ack;
  logic [ADDR_W-1:0] data_addr, jump_target;
  logic [DATA_W-1:0] mem_rdata;
  logic [ADDR_W-1:0] mem_addr, pc;
  logic              mem_req, busy, bus_err;
  logic [DATA_W-1:0] ir, mdr;
  logic [OPC_W-1:0]  opcode;

  fetch_unit #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .OPC_W   (OPC_W),
    .RESET_PC(0),
    .MAX_WAIT(15)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .iord       (iord),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .mem_read   (mem_read),
    .ir_write   (ir_write),
    .data_addr  (data_addr),
    .jump_target(jump_target),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .mem_addr   (mem_addr),
    .mem_req    (mem_req),
    .pc         (pc),
    .ir         (ir),
    .opcode     (opcode),
    .mdr        (mdr),
    .busy       (busy),
    .bus_err    (bus_err)
  );

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              irw;
  } txn_t;

  txn_t sb[$];

  int unsigned       n_vec = 0;
  int unsigned       n_err = 0;
  logic [ADDR_W-1:0] exp_pc;
  logic [DATA_W-1:0] exp_ir;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock; the PC model follows the strobes that were driven for this edge.
  task automatic step();
    if (pc_write) exp_pc = pc_src ? jump_target : exp_pc + 12'd1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    {iord, pc_write, pc_src, mem_read, ir_write, mem_ack} = '0;
    data_addr = '0; jump_target = '0; mem_rdata = '0;
    #1;
    check("rst_pc", pc, 0);
    check("rst_ir", ir, 0);
    check("rst_mdr", mdr, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_req", mem_req, 0);
    check("rst_busy", busy, 0);
    check("rst_err", bus_err, 0);
    @(posedge clk);
    #1 reset = 1'b1;
    exp_pc = '0;
    exp_ir = '0;
  endtask

  task automatic issue(input logic io, input logic [ADDR_W-1:0] da, input logic irw,
                       input logic [DATA_W-1:0] data);
    txn_t t;
    t.addr = io ? da : exp_pc;
    t.data = data;
    t.irw  = irw;
    sb.push_back(t);
    iord = io; data_addr = da; ir_write = irw; mem_read = 1'b1;
    step();
    mem_read = 1'b0; ir_write = 1'b0; iord = 1'b0; pc_write = 1'b0;
    check("iss_req", mem_req, 1);
    check("iss_busy", busy, 1);
    check("iss_addr", mem_addr, t.addr);
  endtask

  task automatic wait_req(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      step();
      check("req_hold", mem_req, 1);
    end
  endtask

  task automatic complete();
    txn_t t;
    if (sb.size() == 0) begin
      n_vec++; n_err++;
      $display("FAIL sb_empty: got 0 entries expected 1");
      return;
    end
    t = sb.pop_front();
    mem_ack = 1'b1; mem_rdata = t.data;
    step();
    mem_ack = 1'b0; mem_rdata = '0;
    if (t.irw) exp_ir = t.data;
    check("cmp_mdr", mdr, t.data);
    check("cmp_ir", ir, exp_ir);
    check("cmp_opc", opcode, exp_ir[DATA_W-1 -: OPC_W]);
    check("cmp_busy", busy, 0);
    check("cmp_req", mem_req, 0);
    check("cmp_addr", mem_addr, t.addr);
  endtask

  task automatic jump(input logic [ADDR_W-1:0] tgt);
    pc_write = 1'b1; pc_src = 1'b1; jump_target = tgt;
    step();
    pc_write = 1'b0; pc_src = 1'b0;
    check("jump_pc", pc, exp_pc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    do_reset();

    // Instruction fetch from PC=0, ack two cycles after the request edge.
    issue(1'b0, 12'h000, 1'b1, 16'hA123);
    wait_req(1);
    complete();
    check("fetch_opc", opcode, 4'hA);

    // Data read with a same-edge PC increment.
    jump(12'h005);
    check("pc5", pc, 12'h005);
    pc_write = 1'b1; pc_src = 1'b0;
    issue(1'b1, 12'h3F0, 1'b0, 16'h0042);
    check("pc6", pc, 12'h006);
    complete();
    check("ir_keep", ir, 16'hA123);

    // PC wrap then jump.
    jump(12'hFFF);
    pc_write = 1'b1; pc_src = 1'b0;
    step();
    pc_write = 1'b0;
    check("pc_wrap", pc, 12'h000);
    jump(12'h123);
    check("pc_jmp", pc, 12'h123);

    // Busy guard: a second request during REQ is dropped, stray ack ignored.
    issue(1'b0, 12'h000, 1'b0, 16'hBEEF);
    mem_read = 1'b1; iord = 1'b1; data_addr = 12'h555; ir_write = 1'b1;
    step();
    mem_read = 1'b0; iord = 1'b0; ir_write = 1'b0;
    check("guard_addr", mem_addr, 12'h123);
    check("guard_req", mem_req, 1);
    complete();
    mem_ack = 1'b1; mem_rdata = 16'h1111;
    step();
    mem_ack = 1'b0;
    check("stray_mdr", mdr, 16'hBEEF);
    check("stray_busy", busy, 0);
    check("stray_ir", ir, 16'hA123);

    // Timeout: 15 REQ cycles with no ack.
    issue(1'b0, 12'h000, 1'b1, 16'h0000);
    void'(sb.pop_back());
    wait_req(14);
    step();
    check("to_req", mem_req, 0);
    check("to_busy", busy, 0);
    check("to_err", bus_err, 1);
    check("to_mdr", mdr, 16'hBEEF);
    check("to_ir", ir, 16'hA123);

    // Still operational after an error; flag stays set.
    issue(1'b1, 12'h010, 1'b0, 16'h0BAD);
    complete();
    check("err_sticky", bus_err, 1);

    // Fresh reset, ack exactly on the timeout edge.
    do_reset();
    issue(1'b0, 12'h000, 1'b1, 16'h7777);
    wait_req(14);
    complete();
    check("late_err", bus_err, 0);
    check("late_opc", opcode, 4'h7);

    // Reset asserted mid-transaction, then a late ack after release.
    jump(12'h0AB);
    issue(1'b1, 12'h200, 1'b1, 16'h9999);
    wait_req(1);
    #2 reset = 1'b0;
    #1;
    check("mid_req", mem_req, 0);
    check("mid_busy", busy, 0);
    check("mid_pc", pc, 0);
    check("mid_ir", ir, 0);
    sb.delete();
    exp_pc = '0;
    exp_ir = '0;
    @(posedge clk);
    #1 reset = 1'b1;
    mem_ack = 1'b1; mem_rdata = 16'h9999;
    step();
    mem_ack = 1'b0;
    check("post_mdr", mdr, 0);
    check("post_ir", ir, 0);
    check("post_req", mem_req, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
